// File: rtl/gcd_engine.sv
// Handshaked GCD engine: one Euclid or Stein iteration per clock, with a
// pass-through tag and a saturating count of iterations per transaction.
module gcd_engine #(
   parameter int WIDTH = 8,
   parameter int ALGO  = 0,
   parameter int TAG_W = 4,
   parameter int CNT_W = 16
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             in_valid_i,
   output logic             in_ready_o,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic [TAG_W-1:0] tag_i,
   output logic             out_valid_o,
   input  logic             out_ready_i,
   output logic [WIDTH-1:0] gcd_o,
   output logic [TAG_W-1:0] tag_o,
   output logic [CNT_W-1:0] cycles_o,
   output logic             busy_o
);

   localparam int KW = $clog2(WIDTH) + 1;
   localparam logic [KW-1:0]    K_ONE   = KW'(1);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_e;

   state_e           state_q;
   logic [WIDTH-1:0] a_q, b_q, a_d, b_d;
   logic [KW-1:0]    k_q, k_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [TAG_W-1:0] tagIn_q;
   logic             outValid_q;
   logic [WIDTH-1:0] gcd_q;
   logic [TAG_W-1:0] tag_q;
   logic [CNT_W-1:0] cycles_q;
   logic             finish;
   logic [WIDTH-1:0] result;

   // One iteration of the selected algorithm; terminating checks take priority.
   always_comb begin
      a_d    = a_q;
      b_d    = b_q;
      k_d    = k_q;
      finish = 1'b0;
      result = '0;
      cnt_d  = (cnt_q == '1) ? cnt_q : cnt_q + CNT_ONE;
      if (a_q == '0) begin
         finish = 1'b1;
         result = b_q << k_q;
      end else if (b_q == '0) begin
         finish = 1'b1;
         result = a_q << k_q;
      end else if (a_q == b_q) begin
         finish = 1'b1;
         result = a_q << k_q;
      end else if (ALGO == 0) begin
         if (a_q > b_q) a_d = a_q - b_q;
         else           b_d = b_q - a_q;
      end else begin
         if (!a_q[0] && !b_q[0]) begin
            a_d = a_q >> 1;
            b_d = b_q >> 1;
            k_d = k_q + K_ONE;
         end else if (!a_q[0]) begin
            a_d = a_q >> 1;
         end else if (!b_q[0]) begin
            b_d = b_q >> 1;
         end else if (a_q > b_q) begin
            a_d = a_q - b_q;
         end else begin
            b_d = b_q - a_q;
         end
      end
   end

   // Control FSM; result fields are captured on CALC exit and held through DONE.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q    <= IDLE;
         a_q        <= '0;
         b_q        <= '0;
         k_q        <= '0;
         cnt_q      <= '0;
         tagIn_q    <= '0;
         outValid_q <= 1'b0;
         gcd_q      <= '0;
         tag_q      <= '0;
         cycles_q   <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (in_valid_i) begin
                  a_q     <= a_i;
                  b_q     <= b_i;
                  tagIn_q <= tag_i;
                  k_q     <= '0;
                  cnt_q   <= '0;
                  state_q <= CALC;
               end
            end
            CALC: begin
               a_q   <= a_d;
               b_q   <= b_d;
               k_q   <= k_d;
               cnt_q <= cnt_d;
               if (finish) begin
                  gcd_q      <= result;
                  tag_q      <= tagIn_q;
                  cycles_q   <= cnt_d;
                  outValid_q <= 1'b1;
                  state_q    <= DONE;
               end
            end
            DONE: begin
               if (out_ready_i) begin
                  outValid_q <= 1'b0;
                  state_q    <= IDLE;
               end
            end
            default: begin
               outValid_q <= 1'b0;
               state_q    <= IDLE;
            end
         endcase
      end
   end

   assign in_ready_o  = (state_q == IDLE);
   assign busy_o      = (state_q == CALC) || (state_q == DONE);
   assign out_valid_o = outValid_q;
   assign gcd_o       = gcd_q;
   assign tag_o       = tag_q;
   assign cycles_o    = cycles_q;

endmodule

// File: tb/tb_gcd_engine.sv
// Scoreboard bench for gcd_engine: Euclid, Stein and a narrow-counter Euclid
// instance, each with its own expected-result queue and output monitor.
module tb_gcd_engine;

   typedef struct {
      logic [7:0]  g;
      logic [3:0]  t;
      logic [15:0] c;
   } exp_t;

   logic        clk;
   logic        rst;
   logic        inValid   [3];
   logic        inReady   [3];
   logic [7:0]  aIn       [3];
   logic [7:0]  bIn       [3];
   logic [3:0]  tagIn     [3];
   logic        outValid  [3];
   logic        outReady  [3];
   logic [7:0]  gcdOut    [3];
   logic [3:0]  tagOut    [3];
   logic [15:0] cyclesOut [3];
   logic        busy      [3];
   logic [3:0]  cycS;
   int          readyMode [3];
   exp_t        expQ      [3][$];
   int          checks   = 0;
   int          failures = 0;

   assign cyclesOut[2] = {12'd0, cycS};

   gcd_engine #(.WIDTH(8), .ALGO(0), .TAG_W(4), .CNT_W(16)) dut0 (
      .clk_i(clk), .rst_i(rst), .in_valid_i(inValid[0]), .in_ready_o(inReady[0]),
      .a_i(aIn[0]), .b_i(bIn[0]), .tag_i(tagIn[0]), .out_valid_o(outValid[0]),
      .out_ready_i(outReady[0]), .gcd_o(gcdOut[0]), .tag_o(tagOut[0]),
      .cycles_o(cyclesOut[0]), .busy_o(busy[0]));

   gcd_engine #(.WIDTH(8), .ALGO(1), .TAG_W(4), .CNT_W(16)) dut1 (
      .clk_i(clk), .rst_i(rst), .in_valid_i(inValid[1]), .in_ready_o(inReady[1]),
      .a_i(aIn[1]), .b_i(bIn[1]), .tag_i(tagIn[1]), .out_valid_o(outValid[1]),
      .out_ready_i(outReady[1]), .gcd_o(gcdOut[1]), .tag_o(tagOut[1]),
      .cycles_o(cyclesOut[1]), .busy_o(busy[1]));

   gcd_engine #(.WIDTH(8), .ALGO(0), .TAG_W(4), .CNT_W(4)) dutS (
      .clk_i(clk), .rst_i(rst), .in_valid_i(inValid[2]), .in_ready_o(inReady[2]),
      .a_i(aIn[2]), .b_i(bIn[2]), .tag_i(tagIn[2]), .out_valid_o(outValid[2]),
      .out_ready_i(outReady[2]), .gcd_o(gcdOut[2]), .tag_o(tagOut[2]),
      .cycles_o(cycS), .busy_o(busy[2]));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Reference gcd by remainders, independent of either iteration scheme.
   function automatic int refGcd(input int a, input int b);
      int t;
      while (b != 0) begin
         t = a % b;
         a = b;
         b = t;
      end
      return a;
   endfunction

   // Subtractive step count derived from quotients; the final equality test is one more cycle.
   function automatic int refEuclidSteps(input int a, input int b);
      int n = 1;
      int hi, lo, q, r;
      while (a != 0 && b != 0 && a != b) begin
         hi = (a > b) ? a : b;
         lo = (a > b) ? b : a;
         q  = hi / lo;
         r  = hi % lo;
         if (r == 0) begin
            n += q - 1;
            a = lo;
            b = lo;
         end else begin
            n += q;
            a = r;
            b = lo;
         end
      end
      return n;
   endfunction

   function automatic int refSteinSteps(input int a, input int b);
      int n = 1;
      while (a != 0 && b != 0 && a != b) begin
         n++;
         if (a % 2 == 0 && b % 2 == 0) begin
            a = a / 2;
            b = b / 2;
         end else if (a % 2 == 0) a = a / 2;
         else if (b % 2 == 0)     b = b / 2;
         else if (a > b)          a = a - b;
         else                     b = b - a;
      end
      return n;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic drive(input int d, input logic [7:0] av, input logic [7:0] bv,
                        input logic [3:0] tv, input bit hold);
      int guard = 0;
      @(negedge clk);
      inValid[d] = 1'b1;
      aIn[d]     = av;
      bIn[d]     = bv;
      tagIn[d]   = tv;
      while (!inReady[d] && guard < 3000) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 3000) begin
         checks++;
         failures++;
         $display("[TB] FAIL accept timeout dut%0d: got waited %0d expected <3000", d, guard);
      end
      @(posedge clk);
      #1;
      if (!hold) inValid[d] = 1'b0;
   endtask

   task automatic applyStimulus(input int d, input logic [7:0] av, input logic [7:0] bv,
                                input logic [3:0] tv, input bit hold);
      exp_t e;
      int   n;
      n = (d == 1) ? refSteinSteps(av, bv) : refEuclidSteps(av, bv);
      if (d == 2 && n > 15) n = 15;
      e.g = 8'(refGcd(av, bv));
      e.t = tv;
      e.c = 16'(n);
      expQ[d].push_back(e);
      drive(d, av, bv, tv, hold);
   endtask

   task automatic applyDirected(input int d, input logic [7:0] av, input logic [7:0] bv,
                                input logic [3:0] tv, input logic [7:0] eg, input logic [15:0] ec);
      exp_t e;
      e.g = eg;
      e.t = tv;
      e.c = ec;
      expQ[d].push_back(e);
      drive(d, av, bv, tv, 1'b0);
   endtask

   task automatic monitorLoop(input int d);
      bit          holdV = 1'b0;
      bit          lastHs = 1'b0;
      logic [7:0]  hg;
      logic [3:0]  ht;
      logic [15:0] hc;
      exp_t        e;
      forever begin
         @(negedge clk);
         case (readyMode[d])
            0:       outReady[d] = 1'b1;
            1:       outReady[d] = 1'($urandom_range(0, 1));
            default: outReady[d] = 1'b0;
         endcase
         if (lastHs) checkOutput($sformatf("dut%0d valid one cycle", d), 32'(outValid[d]), 0);
         lastHs = 1'b0;
         if (rst || !outValid[d]) begin
            holdV = 1'b0;
            continue;
         end
         checkOutput($sformatf("dut%0d in_ready in DONE", d), 32'(inReady[d]), 0);
         if (holdV) begin
            checkOutput($sformatf("dut%0d held gcd", d), 32'(gcdOut[d]), 32'(hg));
            checkOutput($sformatf("dut%0d held tag", d), 32'(tagOut[d]), 32'(ht));
            checkOutput($sformatf("dut%0d held cycles", d), 32'(cyclesOut[d]), 32'(hc));
         end
         if (outReady[d]) begin
            if (expQ[d].size() == 0) begin
               checks++;
               failures++;
               $display("[TB] FAIL dut%0d unexpected output: got gcd %0d expected none", d, gcdOut[d]);
            end else begin
               e = expQ[d].pop_front();
               checkOutput($sformatf("dut%0d gcd", d), 32'(gcdOut[d]), 32'(e.g));
               checkOutput($sformatf("dut%0d tag", d), 32'(tagOut[d]), 32'(e.t));
               checkOutput($sformatf("dut%0d cycles", d), 32'(cyclesOut[d]), 32'(e.c));
            end
            holdV  = 1'b0;
            lastHs = 1'b1;
         end else begin
            holdV = 1'b1;
            hg    = gcdOut[d];
            ht    = tagOut[d];
            hc    = cyclesOut[d];
         end
      end
   endtask

   task automatic drainAll();
      int guard = 0;
      while ((expQ[0].size() + expQ[1].size() + expQ[2].size()) != 0 && guard < 5000) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 5000) begin
         checks++;
         failures++;
         $display("[TB] FAIL drain timeout: got %0d pending expected 0",
                  expQ[0].size() + expQ[1].size() + expQ[2].size());
      end
      repeat (2) @(negedge clk);
   endtask

   task automatic waitValid(input int d);
      int guard = 0;
      while (!outValid[d] && guard < 3000) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 3000) begin
         checks++;
         failures++;
         $display("[TB] FAIL dut%0d valid timeout: got 0 expected 1", d);
      end
   endtask

   task automatic checkResetState(input int d);
      checkOutput($sformatf("dut%0d reset in_ready", d), 32'(inReady[d]), 1);
      checkOutput($sformatf("dut%0d reset busy", d), 32'(busy[d]), 0);
      checkOutput($sformatf("dut%0d reset out_valid", d), 32'(outValid[d]), 0);
      checkOutput($sformatf("dut%0d reset gcd", d), 32'(gcdOut[d]), 0);
      checkOutput($sformatf("dut%0d reset tag", d), 32'(tagOut[d]), 0);
      checkOutput($sformatf("dut%0d reset cycles", d), 32'(cyclesOut[d]), 0);
   endtask

   initial begin
      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         inValid[i]   = 1'b0;
         aIn[i]       = '0;
         bIn[i]       = '0;
         tagIn[i]     = '0;
         outReady[i]  = 1'b1;
         readyMode[i] = 0;
      end
      fork
         monitorLoop(0);
         monitorLoop(1);
         monitorLoop(2);
      join_none
      repeat (3) @(negedge clk);
      for (int i = 0; i < 3; i++) checkResetState(i);
      rst = 1'b0;

      $display("[TB] directed and zero-operand cases");
      applyDirected(0, 8'd18, 8'd12, 4'd3, 8'd6, 16'd3);
      applyDirected(1, 8'd18, 8'd12, 4'd3, 8'd6, 16'd5);
      for (int d = 0; d < 2; d++) begin
         applyDirected(d, 8'd0, 8'd7, 4'd1, 8'd7, 16'd1);
         applyDirected(d, 8'd9, 8'd0, 4'd2, 8'd9, 16'd1);
         applyDirected(d, 8'd0, 8'd0, 4'd4, 8'd0, 16'd1);
      end
      drainAll();

      $display("[TB] back-pressure");
      readyMode[0] = 2;
      applyDirected(0, 8'd6, 8'd6, 4'd5, 8'd6, 16'd1);
      waitValid(0);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (i == 1) begin
            inValid[0] = 1'b1;
            aIn[0]     = 8'd9;
            bIn[0]     = 8'd12;
            tagIn[0]   = 4'd6;
         end
         if (i == 3) inValid[0] = 1'b0;
         checkOutput("stall out_valid", 32'(outValid[0]), 1);
         checkOutput("stall gcd", 32'(gcdOut[0]), 6);
         checkOutput("stall in_ready", 32'(inReady[0]), 0);
         checkOutput("stall busy", 32'(busy[0]), 1);
      end
      inValid[0]   = 1'b0;
      readyMode[0] = 0;
      drainAll();
      checkOutput("post-stall idle", 32'(inReady[0]), 1);
      applyDirected(0, 8'd9, 8'd12, 4'd6, 8'd3, 16'd4);
      drainAll();

      $display("[TB] reset during CALC");
      drive(0, 8'd255, 8'd1, 4'd7, 1'b0);
      repeat (10) @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      checkResetState(0);
      @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("no output after reset", 32'(outValid[0]), 0);
      applyDirected(0, 8'd4, 8'd6, 4'd8, 8'd2, 16'd3);
      drainAll();

      $display("[TB] counter saturation and back-to-back tags");
      applyDirected(2, 8'd255, 8'd1, 4'd9, 8'd1, 16'd15);
      drainAll();
      readyMode[2] = 1;
      for (int i = 0; i < 6; i++)
         applyStimulus(2, 8'($urandom_range(1, 255)), 8'($urandom_range(1, 255)), 4'(i + 10), 1'b1);
      inValid[2] = 1'b0;
      drainAll();

      $display("[TB] randomized traffic");
      readyMode[0] = 1;
      readyMode[1] = 1;
      fork
         for (int i = 0; i < 20; i++)
            applyStimulus(0, ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(0, 255)),
                          8'($urandom_range(0, 255)), 4'($urandom), 1'($urandom_range(0, 1)));
         for (int j = 0; j < 20; j++)
            applyStimulus(1, 8'($urandom_range(0, 255)),
                          ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(0, 255)),
                          4'($urandom), 1'($urandom_range(0, 1)));
      join
      inValid[0] = 1'b0;
      inValid[1] = 1'b0;
      drainAll();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
